barrel_shifter_pipe: RTL and testbench
======================================

// Module: barrel_shifter_pipe
// PURPOSE
//   Parametrised, pipelined barrel shifter; generalises the 16-bit rotate-only shifter to any power-of-two width.
//   Supports rotate, logical shift and arithmetic shift in both directions, with one register stage per shift bit.
//   Uses a valid/ready stream on both sides; sits between the operand-issue logic and the ALU result mux.
// PARAMETERS
//   WIDTH   16  data width; power of two, 4..64; any other value is a $error at elaboration
//   SHW     $clog2(WIDTH)  localparam; shift-amount width, also the pipeline stage count
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous, active-high reset
//   in_valid    in   1      input beat valid
//   in_ready    out  1      block can accept an input beat this cycle
//   in_data     in   WIDTH  operand
//   in_shamt    in   SHW    shift/rotate amount, 0..WIDTH-1
//   in_op       in   3      000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, 101-111 illegal
//   out_valid   out  1      result valid
//   out_ready   in   1      downstream accepts the result
//   out_data    out  WIDTH  result
//   out_illegal out  1      result came from an illegal op
//   out_sticky  out  1      OR of the bits shifted out (BARREL_SHIFTER_STICKY_EN builds only)
// BEHAVIOUR
// - Reset: out_valid, out_data, out_illegal, out_sticky = 0; every stage valid bit = 0; in_ready = 1 on the first cycle after reset.
// - Handshake and stall:
//   - A beat transfers when valid && ready on the same rising edge.
//   - advance = ~out_valid | out_ready; in_ready = advance (combinational, no dependence on in_valid).
//   - Global-stall pipeline: every stage loads from the stage before it only when advance = 1; otherwise all stages hold.
//   - Bubbles move through the pipe like data, so throughput is 1 beat/cycle while out_ready = 1.
//   - While out_valid = 1 and out_ready = 0, out_data, out_illegal and out_sticky stay stable.
// - Latency: exactly SHW cycles from input transfer to out_valid = 1, with no stall; 4 cycles at WIDTH=16.
//   Stage s (s = 0..SHW-1) applies a shift of 2^s when in_shamt[s] = 1; op, shamt and illegal travel with the data.
// - Direction:
//   - Left ops (ROL, SLL) bit-reverse the data at stage-0 input and at the last-stage output.
//   - Internally every stage then performs a right-direction operation.
// - Fill per stage:
//   - ROL/ROR: bits that leave one end re-enter at the other.
//   - SLL/SRL: vacated bits fill with 0.
//   - SRA: vacated bits fill with the original in_data[WIDTH-1], captured at stage 0 and carried down the pipe.
// - in_shamt = 0: out_data = in_data for every legal op; out_sticky = 0.
// - Illegal op (101-111): out_data = in_data unchanged, out_illegal = 1, out_sticky = 0. It still takes SHW cycles and a pipe slot.
// - Reset mid-operation: all in-flight beats are dropped (no output is produced for them); out_valid = 0 the cycle after rst.
// - Inputs are sampled only on a transfer; in_data, in_shamt and in_op may change freely while in_ready = 0.
// CONFIGURATION
//   BARREL_SHIFTER_STICKY_EN defined:
//     - Each stage carries a sticky bit; for SLL, SRL and SRA it ORs in every bit discarded at that stage.
//     - out_sticky = OR of all discarded bits, for FP rounding use; always 0 for rotates and illegal ops.
//   Macro undefined:
//     - The out_sticky port still exists and is tied to 0; no sticky flops are built.
// TESTING (WIDTH=16)
//   1. ROL 0x8001, shamt 1 -> out_data 0x0003 exactly 4 cycles after transfer; ROR 0x1234, shamt 4 -> 0x4123.
//   2. SRA 0x8000, shamt 4 -> 0xF800; SRL 0x8000, shamt 4 -> 0x0800; SLL 0x0001, shamt 15 -> 0x8000; shamt 0 -> data unchanged.
//   3. Streaming: 8 back-to-back beats with out_ready = 1 -> 8 consecutive out_valid cycles, in order, results correct.
//   4. Backpressure: hold out_ready = 0 for 5 cycles with the pipe full -> in_ready = 0, out_data stable;
//      release -> no beat lost or duplicated.
//   5. op 110 on 0xABCD -> out_data 0xABCD, out_illegal = 1; the next legal beat has out_illegal = 0.
//   6. Assert rst with 3 beats in flight -> out_valid = 0 the next cycle and no stale beat emerges later;
//      with STICKY_EN, SRL 0x000F, shamt 2 -> out_sticky = 1, out_data 0x0003.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: rotate, logical and arithmetic shifts, one stage per shamt bit.
// Optional BARREL_SHIFTER_STICKY_EN builds the discarded-bit sticky chain behind out_sticky.
module barrel_shifter_pipe #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_illegal,
  output logic             out_sticky
);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_shifter_pipe: WIDTH must be a power of two in 4..64");
  end

  typedef enum logic [1:0] {
    KIND_ROT,
    KIND_LOG,
    KIND_ARI
  } kind_e;

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Stage-0 decode: left ops are mirrored so every stage shifts right.
  kind_e            dec_kind;
  logic             dec_left;
  logic             dec_ill;
  logic [SHW-1:0]   dec_sh;
  logic [WIDTH-1:0] dec_data;

  always_comb begin
    dec_kind = KIND_ROT;
    dec_left = 1'b0;
    dec_ill  = 1'b0;
    dec_sh   = in_shamt;
    unique case (1'b1)
      (in_op == 3'b000): begin
        dec_kind = KIND_ROT;
        dec_left = 1'b1;
      end
      (in_op == 3'b001): dec_kind = KIND_ROT;
      (in_op == 3'b010): begin
        dec_kind = KIND_LOG;
        dec_left = 1'b1;
      end
      (in_op == 3'b011): dec_kind = KIND_LOG;
      (in_op == 3'b100): dec_kind = KIND_ARI;
      default: begin
        dec_ill = 1'b1;
        dec_sh  = '0;
      end
    endcase
    dec_data = dec_left ? rev(in_data) : in_data;
  end

  logic             v_s  [SHW];
  logic [WIDTH-1:0] d_s  [SHW];
  logic [SHW-1:0]   sh_s [SHW];
  kind_e            k_s  [SHW];
  logic             l_s  [SHW];
  logic             i_s  [SHW];
  logic             sg_s [SHW];

  logic             v_q  [SHW];
  logic [WIDTH-1:0] d_q  [SHW];
  logic [SHW-1:0]   sh_q [SHW];
  kind_e            k_q  [SHW];
  logic             l_q  [SHW];
  logic             i_q  [SHW];
  logic             sg_q [SHW];

`ifdef BARREL_SHIFTER_STICKY_EN
  logic st_s [SHW];
  logic st_q [SHW];
`endif

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    localparam int K = 1 << s;
    localparam bit LAST = (s == SHW - 1);
    localparam logic [WIDTH-1:0] LO = {WIDTH{1'b1}} >> (WIDTH - K);
    localparam logic [WIDTH-1:0] HI = ~({WIDTH{1'b1}} >> K);

    if (s == 0) begin : g_src_in
      assign v_s[s]  = in_valid;
      assign d_s[s]  = dec_data;
      assign sh_s[s] = dec_sh;
      assign k_s[s]  = dec_kind;
      assign l_s[s]  = dec_left;
      assign i_s[s]  = dec_ill;
      assign sg_s[s] = in_data[WIDTH-1];
`ifdef BARREL_SHIFTER_STICKY_EN
      assign st_s[s] = 1'b0;
`endif
    end else begin : g_src_prev
      assign v_s[s]  = v_q[s-1];
      assign d_s[s]  = d_q[s-1];
      assign sh_s[s] = sh_q[s-1];
      assign k_s[s]  = k_q[s-1];
      assign l_s[s]  = l_q[s-1];
      assign i_s[s]  = i_q[s-1];
      assign sg_s[s] = sg_q[s-1];
`ifdef BARREL_SHIFTER_STICKY_EN
      assign st_s[s] = st_q[s-1];
`endif
    end

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] nxt;

    always_comb begin
      shifted = d_s[s];
      if (sh_s[s][s]) begin
        unique case (k_s[s])
          KIND_ROT: shifted = (d_s[s] >> K) | (d_s[s] << (WIDTH - K));
          KIND_LOG: shifted = d_s[s] >> K;
          KIND_ARI: shifted = (d_s[s] >> K) | (sg_s[s] ? HI : '0);
          default:  shifted = d_s[s];
        endcase
      end
      nxt = (LAST && l_s[s]) ? rev(shifted) : shifted;
    end

`ifdef BARREL_SHIFTER_STICKY_EN
    logic st_nxt;
    always_comb begin
      st_nxt = st_s[s];
      if (sh_s[s][s] && k_s[s] != KIND_ROT) begin
        st_nxt = st_s[s] | (|(d_s[s] & LO));
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q[s] <= 1'b0;
      end else if (advance) begin
        st_q[s] <= st_nxt;
      end
    end
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[s]  <= 1'b0;
        d_q[s]  <= '0;
        sh_q[s] <= '0;
        k_q[s]  <= KIND_ROT;
        l_q[s]  <= 1'b0;
        i_q[s]  <= 1'b0;
        sg_q[s] <= 1'b0;
      end else if (advance) begin
        v_q[s]  <= v_s[s];
        d_q[s]  <= nxt;
        sh_q[s] <= sh_s[s];
        k_q[s]  <= k_s[s];
        l_q[s]  <= l_s[s];
        i_q[s]  <= i_s[s];
        sg_q[s] <= sg_s[s];
      end
    end
  end

  assign out_valid   = v_q[SHW-1];
  assign out_data    = d_q[SHW-1];
  assign out_illegal = i_q[SHW-1];

`ifdef BARREL_SHIFTER_STICKY_EN
  assign out_sticky = st_q[SHW-1];
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe at WIDTH=16.
// Covers latency, streaming, backpressure, illegal ops and mid-flight reset.
module tb_barrel_shifter_pipe;
  localparam int W = 16;
  localparam int SHW = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic out_illegal, out_sticky;
  logic [W-1:0] in_data, out_data;
  logic [SHW-1:0] in_shamt;
  logic [2:0] in_op;

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_illegal(out_illegal),
    .out_sticky(out_sticky)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] d;
    logic [3:0]  sh;
    logic [15:0] r;
    logic        ill;
    logic        st;
  } vec_t;

  vec_t vt [18];
  int ntot = 0;
  int npass = 0;
  int cyc = 0;
  bit snd_done;
  logic [17:0] got_q [$];
  int stamp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back({out_illegal, out_sticky, out_data});
      stamp_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send(input int i);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op = vt[i].op;
    in_data = vt[i].d;
    in_shamt = vt[i].sh;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
    #1;
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (got_q.size() < n) check("result_count", got_q.size(), n);
  endtask

  task automatic expect_vec(input int i, output int stamp);
    logic [17:0] g;
    logic st;
    stamp = -1;
    if (got_q.size() == 0) begin
      check($sformatf("missing_%0d", i), 32'd0, 32'd1);
      return;
    end
    g = got_q.pop_front();
    stamp = stamp_q.pop_front();
`ifdef BARREL_SHIFTER_STICKY_EN
    st = vt[i].st;
`else
    st = 1'b0;
`endif
    check($sformatf("data_%0d", i), 32'(g[15:0]), 32'(vt[i].r));
    check($sformatf("ill_%0d", i), 32'(g[17]), 32'(vt[i].ill));
    check($sformatf("sticky_%0d", i), 32'(g[16]), 32'(st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, st0, stmp;
    vt[0]  = '{3'd0, 16'h8001, 4'd1,  16'h0003, 1'b0, 1'b0};
    vt[1]  = '{3'd1, 16'h1234, 4'd4,  16'h4123, 1'b0, 1'b0};
    vt[2]  = '{3'd4, 16'h8000, 4'd4,  16'hF800, 1'b0, 1'b0};
    vt[3]  = '{3'd3, 16'h8000, 4'd4,  16'h0800, 1'b0, 1'b0};
    vt[4]  = '{3'd2, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b0};
    vt[5]  = '{3'd2, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0};
    vt[6]  = '{3'd4, 16'h7FF0, 4'd4,  16'h07FF, 1'b0, 1'b0};
    vt[7]  = '{3'd0, 16'h1234, 4'd4,  16'h2341, 1'b0, 1'b0};
    vt[8]  = '{3'd1, 16'h0001, 4'd1,  16'h8000, 1'b0, 1'b0};
    vt[9]  = '{3'd3, 16'h000F, 4'd2,  16'h0003, 1'b0, 1'b1};
    vt[10] = '{3'd2, 16'hF001, 4'd4,  16'h0010, 1'b0, 1'b1};
    vt[11] = '{3'd4, 16'h8001, 4'd1,  16'hC000, 1'b0, 1'b1};
    vt[12] = '{3'd6, 16'hABCD, 4'd5,  16'hABCD, 1'b1, 1'b0};
    vt[13] = '{3'd5, 16'h1234, 4'd3,  16'h1234, 1'b1, 1'b0};
    vt[14] = '{3'd1, 16'hABCD, 4'd0,  16'hABCD, 1'b0, 1'b0};
    vt[15] = '{3'd0, 16'h8000, 4'd15, 16'h4000, 1'b0, 1'b0};
    vt[16] = '{3'd4, 16'hFFFF, 4'd15, 16'hFFFF, 1'b0, 1'b1};
    vt[17] = '{3'd3, 16'hFFFF, 4'd15, 16'h0001, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_op = '0;
    in_data = '0;
    in_shamt = '0;
    snd_done = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_out_sticky", 32'(out_sticky), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    t0 = cyc;
    send(0);
    in_valid = 1'b0;
    wait_results(1);
    expect_vec(0, stmp);
    check("latency", 32'(stmp - t0), 32'd4);

    for (int i = 1; i < 18; i++) send(i);
    in_valid = 1'b0;
    wait_results(17);
    st0 = -1;
    for (int i = 1; i < 18; i++) begin
      expect_vec(i, stmp);
      if (i == 1) st0 = stmp;
      else if (i <= 8) check($sformatf("stream_gap_%0d", i),
                             32'(stmp - st0), 32'(i - 1));
    end

    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i);
        in_valid = 1'b0;
        snd_done = 1'b1;
      end
    join_none
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!out_valid && k < 100);
      check("bp_fill", 32'(out_valid), 32'd1);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'd0);
      check($sformatf("bp_hold_%0d", c), 32'(out_data), 32'h0003);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_results(8);
    begin
      int k;
      k = 0;
      while (!snd_done && k < 100) begin
        @(posedge clk);
        #1;
        k++;
      end
      check("bp_sender_done", 32'(snd_done), 32'd1);
    end
    repeat (6) @(posedge clk);
    #1;
    check("bp_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) expect_vec(i, stmp);

    send(1);
    send(2);
    send(3);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale", got_q.size(), 0);

    send(9);
    in_valid = 1'b0;
    wait_results(1);
    expect_vec(9, stmp);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
